// File: rtl/scalable_mac_pipe.sv
// Precision-scalable two-stage multiply-accumulate pipeline: one WIDTH x WIDTH lane,
// two WIDTH/2 lanes or four WIDTH/4 lanes, each with its own accumulator and sticky overflow.
module scalable_mac_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   a_sign,
    input  logic                   b_sign,
    input  logic [1:0]             mode,
    input  logic                   acc_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     c,
    output logic [LANES_MAX-1:0]   ovf,
    output logic [1:0]             out_mode
);

    localparam int unsigned CW = 2 * WIDTH;

    logic                 s1_valid_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 a_sign_q;
    logic                 b_sign_q;
    logic [1:0]           mode_q;
    logic                 acc_en_q;

    logic                 out_valid_q;
    logic [CW-1:0]        c_q;
    logic [CW-1:0]        c_d;
    logic [LANES_MAX-1:0] ovf_q;
    logic [LANES_MAX-1:0] ovf_d;
    logic [1:0]           out_mode_q;

    logic                 s1_advance;
    logic                 in_fire;

    assign s1_advance = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready   = ~s1_valid_q | s1_advance;
    assign in_fire    = in_valid & in_ready;

    assign out_valid  = out_valid_q;
    assign c          = c_q;
    assign ovf        = ovf_q;
    assign out_mode   = out_mode_q;

    // Lane arithmetic: everything is done in CW-bit words with per-lane masks so
    // no carry or partial product can leak across a lane boundary.
    int unsigned          l_w;
    int unsigned          n_lanes;
    logic                 use_acc;
    logic                 lane_unsigned;
    logic [CW-1:0]        mask_l;
    logic [CW-1:0]        sbit_l;
    logic [CW-1:0]        mask_p;
    logic [CW-1:0]        sbit_p;
    logic [CW-1:0]        a_l;
    logic [CW-1:0]        b_l;
    logic [CW-1:0]        a_x;
    logic [CW-1:0]        b_x;
    logic [CW-1:0]        prod;
    logic [CW-1:0]        prev;
    logic [CW-1:0]        res;
    logic [CW:0]          sum;
    logic                 carry;
    logic                 p_neg;
    logic                 q_neg;
    logic                 r_neg;
    logic                 lane_ovf;
    logic [LANES_MAX-1:0] ovf_new;

    always_comb begin
        c_d           = '0;
        ovf_new       = '0;
        l_w           = WIDTH >> mode_q;
        n_lanes       = 32'd1 << mode_q;
        use_acc       = acc_en_q & (mode_q == out_mode_q);
        lane_unsigned = ~a_sign_q & ~b_sign_q;
        mask_l        = (CW'(1) << l_w) - CW'(1);
        sbit_l        = CW'(1) << (l_w - 1);
        mask_p        = (CW'(1) << (2 * l_w)) - CW'(1);
        sbit_p        = CW'(1) << (2 * l_w - 1);
        a_l           = '0;
        b_l           = '0;
        a_x           = '0;
        b_x           = '0;
        prod          = '0;
        prev          = '0;
        res           = '0;
        sum           = '0;
        carry         = 1'b0;
        p_neg         = 1'b0;
        q_neg         = 1'b0;
        r_neg         = 1'b0;
        lane_ovf      = 1'b0;
        for (int unsigned k = 0; k < LANES_MAX; k++) begin
            if (k < n_lanes) begin
                a_l   = (CW'(a_q) >> (k * l_w)) & mask_l;
                b_l   = (CW'(b_q) >> (k * l_w)) & mask_l;
                a_x   = (a_sign_q && ((a_l & sbit_l) != '0)) ? (a_l | ~mask_l) : a_l;
                b_x   = (b_sign_q && ((b_l & sbit_l) != '0)) ? (b_l | ~mask_l) : b_l;
                prod  = (a_x * b_x) & mask_p;
                prev  = use_acc ? ((c_q >> (2 * k * l_w)) & mask_p) : '0;
                sum   = {1'b0, prod} + {1'b0, prev};
                res   = sum[CW-1:0] & mask_p;
                carry = ((sum >> (2 * l_w)) & (CW + 1)'(1)) != '0;
                p_neg = (prod & sbit_p) != '0;
                q_neg = (prev & sbit_p) != '0;
                r_neg = (res & sbit_p) != '0;
                lane_ovf = lane_unsigned ? carry : ((p_neg == q_neg) && (r_neg != p_neg));
                c_d     = c_d | (res << (2 * k * l_w));
                ovf_new = ovf_new | (LANES_MAX'(lane_ovf) << k);
            end
        end
        ovf_d = use_acc ? (ovf_q | ovf_new) : '0;
    end

    // S1 operand register; reserved mode 3 is folded to mode 0 on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            mode_q     <= 2'd0;
            acc_en_q   <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            a_q        <= a;
            b_q        <= b;
            a_sign_q   <= a_sign;
            b_sign_q   <= b_sign;
            mode_q     <= (mode == 2'd3) ? 2'd0 : mode;
            acc_en_q   <= acc_en;
        end else if (s1_advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    // S2 result register; c/ovf only change when a new beat arrives from S1.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= '0;
            out_mode_q  <= 2'd0;
        end else if (s1_advance) begin
            out_valid_q <= 1'b1;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            out_mode_q  <= mode_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
